// File: rtl/sha1_core.sv
// sha1_core: SHA-1 compression engine, one round per clock, over one pre-padded 512-bit block.
// Ports:
//   wb_clk_i, reset      clock and asynchronous active-high reset
//   start, init          begin a block (IDLE only); init=1 reloads H with the IV first
//   in_valid/in_ready    16 big-endian 32-bit message words on in_data, W[0] first
//   busy, done           busy in LOAD/ROUND/UPDATE; done pulses once when digest is new
//   digest               {H0,H1,H2,H3,H4}, H0 in [159:128]
//   dbg_round, dbg_a     round counter / register A observation
// Build option: define SHA1_ROUND_OBS_EN to drive dbg_round/dbg_a; otherwise both are tied to 0.
module sha1_core (
    input  logic         wb_clk_i,
    input  logic         reset,
    input  logic         start,
    input  logic         init,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         busy,
    output logic         done,
    output logic [159:0] digest,
    output logic [6:0]   dbg_round,
    output logic [31:0]  dbg_a
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, UPDATE} state_t;
    localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    state_t       state_q, state_d;
    logic [159:0] h_q, h_d, h_init;
    logic [31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d;
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [3:0]   cnt_q, cnt_d;
    logic [6:0]   t_q, t_d;
    logic         done_q, done_d;
    logic [3:0]   i3, i8, i14;
    logic [31:0]  w_x, wt, f, k, temp;
    assign h_init = init ? IV : h_q;
    // The 16-entry buffer holds W[t-16..t-1]; slot t mod 16 is both W[t-16] and the write-back slot.
    assign i3   = t_q[3:0] - 4'd3;
    assign i8   = t_q[3:0] - 4'd8;
    assign i14  = t_q[3:0] - 4'd14;
    assign w_x  = w_q[i3] ^ w_q[i8] ^ w_q[i14] ^ w_q[t_q[3:0]];
    assign wt   = (t_q < 7'd16) ? w_q[t_q[3:0]] : {w_x[30:0], w_x[31]};
    assign f    = (t_q < 7'd20) ? ((b_q & c_q) | (~b_q & d_q)) :
                  (t_q < 7'd40 || t_q >= 7'd60) ? (b_q ^ c_q ^ d_q) :
                  ((b_q & c_q) | (b_q & d_q) | (c_q & d_q));
    assign k    = (t_q < 7'd20) ? 32'h5a827999 : (t_q < 7'd40) ? 32'h6ed9eba1 :
                  (t_q < 7'd60) ? 32'h8f1bbcdc : 32'hca62c1d6;
    assign temp = {a_q[26:0], a_q[31:27]} + f + e_q + k + wt;
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                h_d     = h_init;
                {a_d, b_d, c_d, d_d, e_d} = h_init;
                cnt_d   = 4'd0;
                state_d = LOAD;
            end
            LOAD: if (in_valid) begin
                w_d[cnt_q] = in_data;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    t_d     = 7'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                w_d[t_q[3:0]] = wt;
                e_d     = d_q;
                d_d     = c_q;
                c_d     = {b_q[1:0], b_q[31:2]};
                b_d     = a_q;
                a_d     = temp;
                t_d     = (t_q == 7'd79) ? 7'd0 : t_q + 7'd1;
                state_d = (t_q == 7'd79) ? UPDATE : ROUND;
            end
            UPDATE: begin
                h_d     = {h_q[159:128] + a_q, h_q[127:96] + b_q, h_q[95:64] + c_q,
                           h_q[63:32] + d_q, h_q[31:0] + e_q};
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            h_q     <= IV;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            cnt_q   <= '0;
            t_q     <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            done_q  <= done_d;
            w_q     <= w_d;
        end
    end
    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign digest   = h_q;
`ifdef SHA1_ROUND_OBS_EN
    assign dbg_round = (state_q == ROUND) ? t_q : 7'd0;
    assign dbg_a     = a_q;
`else
    assign dbg_round = 7'd0;
    assign dbg_a     = 32'd0;
`endif
endmodule
